// File: rtl/mem_responder.sv
// mem_responder: memory-side responder for the core's external bus.
// Serves reads, writes and two-beat fetches over a strobe/ack memory.
module mem_responder #(
  parameter int ADDR_W = 18
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       cpu_addr,
  input  logic [15:0]       cpu_wdata,
  input  logic              cpu_read,
  input  logic              cpu_write,
  input  logic              cpu_instr,
  input  logic              cpu_read_done,
  output logic [15:0]       cpu_rdata,
  output logic [31:0]       cpu_instr_data,
  output logic              cpu_busy,
  output logic              cpu_cack,
  output logic              cpu_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic              mem_re,
  output logic              mem_we,
  input  logic [15:0]       mem_rdata,
  input  logic              mem_ack
);

  typedef enum logic [2:0] {
    IDLE, RD, WR, IF0, IF1, HOLD
  } state_t;

  state_t state, state_d;

  logic [15:0]       addr_q, addr_d;
  logic [15:0]       low_q, low_d;
  logic [15:0]       rdata_d;
  logic [31:0]       idata_d;
  logic              busy_d, cack_d, ready_d;
  logic [ADDR_W-1:0] maddr_d;
  logic [15:0]       wdata_d;
  logic              re_d, we_d;
  logic              rd_arm, rd_arm_d;
  logic              wr_arm, wr_arm_d;
  logic              take_wr, take_rd;

  function automatic logic [ADDR_W-1:0] data_addr(
    input logic [15:0] a
  );
    return ADDR_W'({2'b00, a});
  endfunction

  function automatic logic [ADDR_W-1:0] fetch_addr(
    input logic [15:0] a,
    input logic        beat
  );
    return ADDR_W'({1'b1, a, beat});
  endfunction

  assign take_wr = cpu_write && wr_arm;
  assign take_rd = cpu_read && rd_arm && !take_wr;

  // Next-state and next-output decode; every register holds by default.
  always_comb begin
    state_d  = state;
    addr_d   = addr_q;
    low_d    = low_q;
    rdata_d  = cpu_rdata;
    idata_d  = cpu_instr_data;
    busy_d   = cpu_busy;
    cack_d   = 1'b0;
    ready_d  = cpu_ready;
    maddr_d  = mem_addr;
    wdata_d  = mem_wdata;
    re_d     = mem_re;
    we_d     = mem_we;
    rd_arm_d = rd_arm | ~cpu_read;
    wr_arm_d = wr_arm | ~cpu_write;
    unique case (state)
      IDLE: begin
        if (take_wr || take_rd) begin
          addr_d  = cpu_addr;
          wdata_d = cpu_wdata;
          cack_d  = 1'b1;
          busy_d  = 1'b1;
        end
        if (take_wr) begin
          state_d  = WR;
          wr_arm_d = 1'b0;
          we_d     = 1'b1;
          maddr_d  = data_addr(cpu_addr);
        end else if (take_rd) begin
          rd_arm_d = 1'b0;
          re_d     = 1'b1;
          if (cpu_instr) begin
            state_d = IF0;
            maddr_d = fetch_addr(cpu_addr, 1'b0);
          end else begin
            state_d = RD;
            maddr_d = data_addr(cpu_addr);
          end
        end
      end
      WR: begin
        if (mem_ack) begin
          we_d    = 1'b0;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      RD: begin
        if (mem_ack) begin
          rdata_d = mem_rdata;
          re_d    = 1'b0;
          busy_d  = 1'b0;
          ready_d = 1'b1;
          state_d = HOLD;
        end
      end
      IF0: begin
        if (mem_ack) begin
          low_d   = mem_rdata;
          maddr_d = fetch_addr(addr_q, 1'b1);
          state_d = IF1;
        end
      end
      IF1: begin
        if (mem_ack) begin
          idata_d = {mem_rdata, low_q};
          re_d    = 1'b0;
          busy_d  = 1'b0;
          ready_d = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (cpu_read_done) begin
          ready_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset aborts any access in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      addr_q         <= '0;
      low_q          <= '0;
      cpu_rdata      <= '0;
      cpu_instr_data <= '0;
      cpu_busy       <= 1'b0;
      cpu_cack       <= 1'b0;
      cpu_ready      <= 1'b0;
      mem_addr       <= '0;
      mem_wdata      <= '0;
      mem_re         <= 1'b0;
      mem_we         <= 1'b0;
      rd_arm         <= 1'b1;
      wr_arm         <= 1'b1;
    end else begin
      state          <= state_d;
      addr_q         <= addr_d;
      low_q          <= low_d;
      cpu_rdata      <= rdata_d;
      cpu_instr_data <= idata_d;
      cpu_busy       <= busy_d;
      cpu_cack       <= cack_d;
      cpu_ready      <= ready_d;
      mem_addr       <= maddr_d;
      mem_wdata      <= wdata_d;
      mem_re         <= re_d;
      mem_we         <= we_d;
      rd_arm         <= rd_arm_d;
      wr_arm         <= wr_arm_d;
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed and random checks of mem_responder
// against a backing-memory model and an address-level reference.
module tb_mem_responder;

  localparam int ADDR_W = 18;
  localparam int K_RD   = 0;
  localparam int K_WR   = 1;
  localparam int K_IF   = 2;
  localparam int FBASE  = 131072;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [15:0]       cpu_addr = '0;
  logic [15:0]       cpu_wdata = '0;
  logic              cpu_read = 1'b0;
  logic              cpu_write = 1'b0;
  logic              cpu_instr = 1'b0;
  logic              cpu_read_done = 1'b0;
  logic [15:0]       cpu_rdata;
  logic [31:0]       cpu_instr_data;
  logic              cpu_busy;
  logic              cpu_cack;
  logic              cpu_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_wdata;
  logic              mem_re;
  logic              mem_we;
  logic [15:0]       mem_rdata = '0;
  logic              mem_ack = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  int ack_delay = 0;
  bit ack_en = 1'b1;
  bit stray = 1'b0;
  int cnt = 0;

  logic [15:0] bmem [int];
  logic [15:0] ref_mem [int];
  logic [15:0] exp_rdata = '0;
  logic [31:0] exp_instr = '0;

  mem_responder #(.ADDR_W(ADDR_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .cpu_addr       (cpu_addr),
    .cpu_wdata      (cpu_wdata),
    .cpu_read       (cpu_read),
    .cpu_write      (cpu_write),
    .cpu_instr      (cpu_instr),
    .cpu_read_done  (cpu_read_done),
    .cpu_rdata      (cpu_rdata),
    .cpu_instr_data (cpu_instr_data),
    .cpu_busy       (cpu_busy),
    .cpu_cack       (cpu_cack),
    .cpu_ready      (cpu_ready),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_re         (mem_re),
    .mem_we         (mem_we),
    .mem_rdata      (mem_rdata),
    .mem_ack        (mem_ack)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] init_val(input int a);
    int unsigned h;
    h = unsigned'(a) * 32'd2654435761;
    return h[31:16];
  endfunction

  function automatic logic [15:0] bm_rd(input int a);
    return bmem.exists(a) ? bmem[a] : init_val(a);
  endfunction

  function automatic logic [15:0] rm_rd(input int a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  // Backing memory: acks each strobed beat after ack_delay wait cycles.
  always @(posedge clk) begin
    #1;
    if (!rst) begin
      mem_ack = 1'b0;
      cnt = 0;
    end else if (mem_re || mem_we) begin
      if (ack_en && cnt >= ack_delay) begin
        mem_ack = 1'b1;
        if (mem_we) bmem[int'(mem_addr)] = mem_wdata;
        else mem_rdata = bm_rd(int'(mem_addr));
        cnt = 0;
      end else begin
        mem_ack = 1'b0;
        cnt++;
      end
    end else begin
      mem_ack = stray;
      cnt = 0;
      if (stray) mem_rdata = 16'($urandom);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic txn(input int kind, input logic [15:0] a,
                     input logic [15:0] wd, input int dly,
                     input int extra);
    int cyc, lat, cacks, strb, rdy_w, bad, ai, beats;
    logic [31:0] a0, a1, w0;
    ai = int'(a);
    beats = (kind == K_IF) ? 2 : 1;
    ack_delay = dly;
    cpu_addr  = a;
    cpu_wdata = wd;
    cpu_instr = (kind == K_IF);
    cpu_write = (kind == K_WR);
    cpu_read  = (kind != K_WR);
    cyc = 0; lat = 0; cacks = 0; strb = 0; rdy_w = 0;
    a0 = '0; a1 = '0; w0 = '0;
    while (lat == 0 && cyc < 64) begin
      @(negedge clk);
      cyc++;
      if (cpu_cack) cacks++;
      if (mem_re || mem_we) strb++;
      if (cyc == 1) begin
        a0 = 32'(mem_addr);
        w0 = 32'(mem_wdata);
      end
      if (cyc == 2 + dly) a1 = 32'(mem_addr);
      if (kind == K_WR) begin
        if (cpu_ready) rdy_w++;
        if (!cpu_busy) lat = cyc;
      end else if (cpu_ready) lat = cyc;
    end
    chk("latency", 32'(lat),
        32'((kind == K_IF) ? 3 + 2 * dly : 2 + dly));
    chk("cack_count", 32'(cacks), 32'd1);
    chk("strobe_cycles", 32'(strb), 32'(beats * (dly + 1)));
    chk("addr_beat0", a0, 32'((kind == K_IF) ? FBASE + 2 * ai : ai));
    if (kind == K_IF) chk("addr_beat1", a1, 32'(FBASE + 2 * ai + 1));
    if (kind == K_WR) begin
      ref_mem[ai] = wd;
      chk("wr_wdata", w0, 32'(wd));
      chk("wr_no_ready", 32'(rdy_w), 32'd0);
      bad = 0;
      repeat (extra) begin
        @(negedge clk);
        if (cpu_cack || mem_we || cpu_busy) bad++;
      end
      cpu_write = 1'b0;
      @(negedge clk);
      if (cpu_cack || mem_we || cpu_busy) bad++;
      chk("wr_once", 32'(bad), 32'd0);
    end else begin
      if (kind == K_IF)
        exp_instr = {rm_rd(FBASE + 2 * ai + 1), rm_rd(FBASE + 2 * ai)};
      else
        exp_rdata = rm_rd(ai);
      bad = 0;
      repeat (extra) begin
        @(negedge clk);
        if (!cpu_ready || cpu_cack || cpu_busy) bad++;
      end
      chk("ready_hold", 32'(bad), 32'd0);
      cpu_read_done = 1'b1;
      cpu_read = 1'b0;
      cpu_instr = 1'b0;
      @(negedge clk);
      cpu_read_done = 1'b0;
      chk("ready_release", 32'({cpu_ready, cpu_busy}), 32'd0);
    end
    chk("rdata", 32'(cpu_rdata), 32'(exp_rdata));
    chk("instr_data", cpu_instr_data, exp_instr);
  endtask

  initial begin
    int cyc, lat, cacks, kind, dly, extra;
    logic first_we;
    logic [15:0] a, wd;

    // Reset state
    @(negedge clk);
    chk("reset_ctl",
        32'({cpu_busy, cpu_cack, cpu_ready, mem_re, mem_we}), 32'd0);
    chk("reset_rdata", 32'(cpu_rdata), 32'd0);
    chk("reset_instr", cpu_instr_data, 32'd0);
    chk("reset_maddr", 32'(mem_addr), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Directed: read with two wait cycles
    bmem[32'h1234] = 16'hBEEF;
    ref_mem[32'h1234] = 16'hBEEF;
    txn(K_RD, 16'h1234, 16'h0000, 2, 2);

    // Directed: fetch with ack tied high
    bmem[FBASE + 32] = 16'h5678;
    bmem[FBASE + 33] = 16'h1234;
    ref_mem[FBASE + 32] = 16'h5678;
    ref_mem[FBASE + 33] = 16'h1234;
    txn(K_IF, 16'h0010, 16'h0000, 0, 1);
    chk("fetch_word", cpu_instr_data, 32'h1234_5678);
    chk("fetch_keeps_rdata", 32'(cpu_rdata), 32'h0000_BEEF);

    // Directed: write held high for five cycles, then read back
    txn(K_WR, 16'h00FF, 16'hA5A5, 0, 3);
    txn(K_RD, 16'h00FF, 16'h0000, 0, 0);
    chk("write_readback", 32'(cpu_rdata), 32'h0000_A5A5);

    // Read and write together: write first, then read
    ack_delay = 0;
    a = 16'h0042;
    wd = 16'h3C96;
    cpu_addr = a;
    cpu_wdata = wd;
    cpu_instr = 1'b0;
    cpu_read = 1'b1;
    cpu_write = 1'b1;
    cyc = 0; lat = 0; cacks = 0; first_we = 1'b0;
    while (lat == 0 && cyc < 64) begin
      @(negedge clk);
      cyc++;
      if (cpu_cack) cacks++;
      if (cyc == 1) first_we = mem_we;
      if (cpu_ready) lat = cyc;
    end
    ref_mem[int'(a)] = wd;
    exp_rdata = wd;
    chk("both_cacks", 32'(cacks), 32'd2);
    chk("both_write_first", 32'(first_we), 32'd1);
    chk("both_latency", 32'(lat), 32'd4);
    chk("both_rdata", 32'(cpu_rdata), 32'(wd));
    cpu_read_done = 1'b1;
    cpu_read = 1'b0;
    cpu_write = 1'b0;
    @(negedge clk);
    cpu_read_done = 1'b0;
    chk("both_release", 32'(cpu_ready), 32'd0);

    // Reset in the second fetch beat with no ack coming
    ack_delay = 0;
    cpu_addr = 16'h0100;
    cpu_instr = 1'b1;
    cpu_read = 1'b1;
    @(negedge clk);
    ack_en = 1'b0;
    @(negedge clk);
    chk("rst_if1_addr", 32'(mem_addr), 32'(FBASE + 2 * 256 + 1));
    chk("rst_if1_re", 32'(mem_re), 32'd1);
    @(negedge clk);
    #1 rst = 1'b0;
    #1;
    chk("rst_async_ctl",
        32'({cpu_busy, cpu_cack, cpu_ready, mem_re, mem_we}), 32'd0);
    chk("rst_async_data", 32'(cpu_rdata), 32'd0);
    chk("rst_async_instr", cpu_instr_data, 32'd0);
    exp_rdata = '0;
    exp_instr = '0;
    cpu_read = 1'b0;
    cpu_instr = 1'b0;
    ack_en = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_idle", 32'({cpu_busy, mem_re, cpu_ready}), 32'd0);
    txn(K_IF, 16'h0100, 16'h0000, 1, 0);
    txn(K_RD, 16'h1234, 16'h0000, 0, 0);

    // Stray ack and read_done while idle
    stray = 1'b1;
    cpu_read_done = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("stray_ctl",
          32'({cpu_busy, cpu_cack, cpu_ready, mem_re, mem_we}), 32'd0);
      chk("stray_rdata", 32'(cpu_rdata), 32'(exp_rdata));
    end
    stray = 1'b0;
    cpu_read_done = 1'b0;
    @(negedge clk);

    // Random mix against the reference
    for (int i = 0; i < 40; i++) begin
      kind = int'($urandom_range(0, 2));
      dly = int'($urandom_range(0, 3));
      extra = int'($urandom_range(0, 3));
      wd = 16'($urandom);
      if ($urandom_range(0, 1) == 0) a = 16'($urandom_range(0, 15));
      else a = 16'($urandom);
      txn(kind, a, wd, dly, extra);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
